// File: rtl/ddr_phase_train.sv
// DDR read-clock phase trainer: sweeps every PLL phase step across all lanes, centres on the
// longest (wrap-aware) passing window, pulses the datapath reset, then watches alignment.
module ddr_phase_train #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned PHASE_W   = 4,
    parameter int unsigned TMR_W     = 8,
    parameter int unsigned RTY_W     = 8,
    parameter int unsigned MIN_WIN   = 6,
    parameter int unsigned RST_CYC   = 8,
    parameter int unsigned STOP_CYC  = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lock,
    input  logic [NUM_LANES-1:0] phase_err,
    input  logic [NUM_LANES-1:0] align_err,
    input  logic                 reset_datapath,
    output logic [PHASE_W-1:0]   phase,
    output logic                 reset_datapath_out,
    output logic                 stop_out,
    output logic                 good,
    output logic                 err,
    output logic [PHASE_W-1:0]   win_start,
    output logic [PHASE_W:0]     win_len
);
    localparam int unsigned N     = 1 << PHASE_W;
    localparam int unsigned LEN_W = PHASE_W + 1;
    localparam int unsigned IDX_W = PHASE_W + 1;

    localparam logic [TMR_W-1:0]   TMR_MAX     = '1;
    localparam logic [TMR_W-1:0]   TMR_RST_END = TMR_MAX - TMR_W'(1);
    localparam logic [RTY_W-1:0]   RTY_MAX     = '1;
    localparam logic [PHASE_W-1:0] PHASE_MAX   = '1;
    localparam logic [IDX_W-1:0]   IDX_LAST    = '1;
    localparam logic [LEN_W-1:0]   LEN_MAX     = LEN_W'(N);

    typedef enum logic [2:0] {
        IDLE, SWEEP, SELECT, SEEK, RST_DP, CHECK, GOOD, ERR
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q;
    logic                 timer_rst;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic [N-1:0]         pass_q, pass_d;
    logic [IDX_W-1:0]     sel_idx_q, sel_idx_d;
    logic [LEN_W-1:0]     run_q, run_d;
    logic [LEN_W-1:0]     best_len_q, best_len_d;
    logic [PHASE_W-1:0]   best_end_q, best_end_d;
    logic [PHASE_W-1:0]   target_q, target_d;
    logic [PHASE_W-1:0]   win_start_q, win_start_d;
    logic [LEN_W-1:0]     win_len_q, win_len_d;
    logic                 rdo_q, stop_q, good_q, err_q;

    logic                 lock_ff, reset_datapath_ff;
    logic [NUM_LANES-1:0] phase_err_ff, align_err_ff;

    logic                 sel_pass;
    logic [LEN_W-1:0]     run_nxt;
    logic [LEN_W-1:0]     scan_len;
    logic [PHASE_W-1:0]   scan_end;
    logic [PHASE_W-1:0]   scan_start;
    logic [PHASE_W-1:0]   scan_tgt;
    logic                 lock_watch;

    // Input capture; every decision uses these copies
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_ff           <= 1'b0;
            phase_err_ff      <= '0;
            align_err_ff      <= '0;
            reset_datapath_ff <= 1'b0;
        end else begin
            lock_ff           <= lock;
            phase_err_ff      <= phase_err;
            align_err_ff      <= align_err;
            reset_datapath_ff <= reset_datapath;
        end
    end

    // Window scan step: fold the current pass bit into run/best, and derive the centre
    always_comb begin
        sel_pass = pass_q[sel_idx_q[PHASE_W-1:0]];
        run_nxt  = '0;
        if (sel_pass) begin
            run_nxt = (run_q == LEN_MAX) ? run_q : run_q + LEN_W'(1);
        end
        scan_len = best_len_q;
        scan_end = best_end_q;
        if (run_nxt > best_len_q) begin
            scan_len = run_nxt;
            scan_end = sel_idx_q[PHASE_W-1:0];
        end
        scan_start = scan_end - scan_len[PHASE_W-1:0] + PHASE_W'(1);
        scan_tgt   = scan_start + scan_len[PHASE_W:1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        retry_d     = retry_q;
        pass_d      = pass_q;
        sel_idx_d   = sel_idx_q;
        run_d       = run_q;
        best_len_d  = best_len_q;
        best_end_d  = best_end_q;
        target_d    = target_q;
        win_start_d = win_start_q;
        win_len_d   = win_len_q;
        timer_rst   = 1'b0;
        lock_watch  = (state_q != IDLE) && (state_q != ERR);

        if (lock_watch && !lock_ff) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lock_ff) begin
                        state_d = SWEEP;
                        phase_d = '0;
                        retry_d = '0;
                        pass_d  = '0;
                    end
                end
                SWEEP: begin
                    if (timer_q == TMR_MAX) begin
                        pass_d[phase_q] = ~|phase_err_ff;
                        if (phase_q == PHASE_MAX) begin
                            state_d    = SELECT;
                            sel_idx_d  = '0;
                            run_d      = '0;
                            best_len_d = '0;
                            best_end_d = '0;
                        end else begin
                            phase_d   = phase_q + PHASE_W'(1);
                            timer_rst = 1'b1;
                        end
                    end
                end
                SELECT: begin
                    sel_idx_d  = sel_idx_q + IDX_W'(1);
                    run_d      = run_nxt;
                    best_len_d = scan_len;
                    best_end_d = scan_end;
                    if (sel_idx_q == IDX_LAST) begin
                        if (scan_len < LEN_W'(MIN_WIN)) begin
                            if (retry_q == RTY_MAX) begin
                                state_d = ERR;
                            end else begin
                                retry_d = retry_q + RTY_W'(1);
                                state_d = SWEEP;
                                phase_d = '0;
                            end
                        end else begin
                            state_d     = SEEK;
                            win_start_d = scan_start;
                            win_len_d   = scan_len;
                            target_d    = scan_tgt;
                        end
                    end
                end
                SEEK: begin
                    if (phase_q == target_q) begin
                        state_d = RST_DP;
                    end else if (timer_q == TMR_MAX) begin
                        phase_d   = phase_q + PHASE_W'(1);
                        timer_rst = 1'b1;
                    end
                end
                RST_DP: begin
                    if (timer_q == TMR_RST_END) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (~|align_err_ff) begin
                        state_d = GOOD;
                    end else if (retry_q == RTY_MAX) begin
                        state_d = ERR;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = RST_DP;
                    end
                end
                GOOD: begin
                    retry_d = '0;
                    if (|phase_err_ff) begin
                        state_d = IDLE;
                    end else if (|align_err_ff || reset_datapath_ff) begin
                        state_d = RST_DP;
                    end
                end
                ERR: begin
                    if (reset_datapath_ff) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath registers; status outputs are also gated by lock so they drop ahead of the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q     <= '0;
            phase_q     <= '0;
            retry_q     <= '0;
            pass_q      <= '0;
            sel_idx_q   <= '0;
            run_q       <= '0;
            best_len_q  <= '0;
            best_end_q  <= '0;
            target_q    <= '0;
            win_start_q <= '0;
            win_len_q   <= '0;
            rdo_q       <= 1'b0;
            stop_q      <= 1'b0;
            good_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if ((state_d != state_q) || timer_rst) begin
                timer_q <= '0;
            end else if (timer_q != TMR_MAX) begin
                timer_q <= timer_q + TMR_W'(1);
            end
            phase_q     <= phase_d;
            retry_q     <= retry_d;
            pass_q      <= pass_d;
            sel_idx_q   <= sel_idx_d;
            run_q       <= run_d;
            best_len_q  <= best_len_d;
            best_end_q  <= best_end_d;
            target_q    <= target_d;
            win_start_q <= win_start_d;
            win_len_q   <= win_len_d;
            rdo_q       <= (state_q == RST_DP) && (timer_q < TMR_W'(RST_CYC)) && lock_ff;
            stop_q      <= (state_q == RST_DP) && (timer_q < TMR_W'(STOP_CYC)) && lock_ff;
            good_q      <= (state_q == GOOD) && (timer_q == TMR_MAX) && lock_ff;
            err_q       <= (state_q == ERR);
        end
    end

    assign phase              = phase_q;
    assign reset_datapath_out = rdo_q;
    assign stop_out           = stop_q;
    assign good               = good_q;
    assign err                = err_q;
    assign win_start          = win_start_q;
    assign win_len            = win_len_q;

endmodule
